// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble converter from 14-bit binary to four BCD digits
// Ports:
//   clock, reset   rising-edge clock; asynchronous active-high reset
//   value          14-bit unsigned binary input, captured when a conversion starts
//   start          conversion request, sampled only while idle
//   busy           high from the accepting edge until the result edge
//   done           one-cycle pulse; results change on the same edge
//   digit0..3      BCD ones, tens, hundreds, thousands (saturate to 9999 on overflow)
//   overflow       last converted value exceeded 9999
//   lead_mask      bit i set when digit i or any higher digit is non-zero; bit 0 always set
module bcd_seq_converter #(
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic        overflow,
  output logic [3:0]  lead_mask
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [13:0] shift_q, shift_d, last_value_q, last_value_d;
  logic [15:0] scratch_q, scratch_d, result_q, result_d, adj;
  logic [3:0]  count_q, count_d, lead_mask_q, lead_mask_d;
  logic        done_q, done_d, overflow_q, overflow_d, trigger;
  assign trigger = start || (AUTO_RESTART && value != last_value_q);
  // +3 correction on every nibble >= 5, applied before each shift only
  always_comb begin
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = scratch_q[4*i +: 4] >= 4'd5 ? scratch_q[4*i +: 4] + 4'd3 : scratch_q[4*i +: 4];
  end
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    last_value_d = last_value_q;
    scratch_d    = scratch_q;
    count_d      = count_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: if (trigger) begin
        shift_d      = value;
        last_value_d = value;
        scratch_d    = 16'd0;
        count_d      = 4'd0;
        state_d      = SHIFT;
      end
      SHIFT: begin
        scratch_d = {adj[14:0], shift_q[13]};
        shift_d   = {shift_q[12:0], 1'b0};
        count_d   = count_q + 4'd1;
        if (count_q == 4'd13) state_d = DONE;
      end
      DONE: begin
        // scratch only holds four digits, so out-of-range values saturate instead
        overflow_d = last_value_q > 14'd9999;
        result_d   = overflow_d ? 16'h9999 : scratch_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign lead_mask_d = {|result_d[15:12], |result_d[15:8], |result_d[15:4], 1'b1};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      last_value_q <= '0;
      scratch_q    <= '0;
      count_q      <= '0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
      lead_mask_q  <= 4'b0001;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      last_value_q <= last_value_d;
      scratch_q    <= scratch_d;
      count_q      <= count_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
      lead_mask_q  <= lead_mask_d;
      done_q       <= done_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign digit0    = result_q[3:0];
  assign digit1    = result_q[7:4];
  assign digit2    = result_q[11:8];
  assign digit3    = result_q[15:12];
  assign overflow  = overflow_q;
  assign lead_mask = lead_mask_q;
endmodule

// File: doc/bcd_seq_converter.md
BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 Parameter: AUTO_RESTART, default 0, meaning: 1 = start a new conversion whenever value differs from the last value converted, regardless of the start pin.
REQ-002 Port: clock  input  1  system clock (100 MHz); all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: value  input  14  unsigned binary count to convert (e.g. from the up/down counter).
REQ-005 Port: start  input  1  request pulse or level; sampled only in IDLE.
REQ-006 Port: busy  output  1  high while a conversion is in progress.
REQ-007 Port: done  output  1  one-cycle pulse; results updated on the same edge.
REQ-008 Port: digit0, digit1, digit2, digit3  output  4 each  BCD ones, tens, hundreds and thousands; feed the display digit mux directly.
REQ-009 Port: overflow  output  1  last converted value was greater than 9999.
REQ-010 Port: lead_mask  output  4  bit i = 1 if digit i or any higher digit is non-zero; bit 0 always 1; used to blank leading zeros.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE SHALL accept a trigger (start=1, or AUTO_RESTART=1 and value != last_value) at edge N; it captures value into a 14-bit shift register and last_value, clears the 16-bit BCD scratch and the 4-bit iteration count, and enters SHIFT with busy=1.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle: each scratch nibble >= 5 gets +3, then scratch and shift register shift left one bit, with the shift register MSB entering the scratch LSB.
REQ-014 SHIFT SHALL last exactly 14 cycles, at edges N+1 to N+14, and move to DONE on the edge that completes iteration 14.
REQ-015 At edge N+15, DONE SHALL register digit0..3, overflow and lead_mask, assert done for exactly one cycle, drop busy, and return to IDLE.
REQ-016 Latency SHALL be fixed: done is high during the cycle after edge N+15 for every input value.
REQ-017 Overflow: when the captured value exceeds 9999, the outputs SHALL be digit3..0 = 9,9,9,9, overflow=1 and lead_mask=1111; the latency is unchanged.
REQ-018 digit0..3, overflow and lead_mask SHALL change only on the done edge and hold their previous values while busy, so the display never shows partial results.
REQ-019 A start asserted in SHIFT or DONE SHALL be ignored, with no queuing; a change of value during SHIFT SHALL NOT affect the conversion in progress.
REQ-020 With start held high, conversions SHALL run back-to-back, one every 16 cycles (the IDLE cycle re-accepts start).
REQ-021 All arithmetic SHALL stay within 4-bit nibbles; the +3 correction is applied only before the shift, never after the final shift.
REQ-022 lead_mask SHALL be computed from the registered result digits, e.g. 0070 gives 0011 and 0000 gives 0001.

Reset
REQ-023 Asynchronous reset SHALL force state IDLE, busy=0, done=0, digit0..3=0, overflow=0, lead_mask=0001, and clear the scratch, shift register, iteration count and last_value.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; after release, the block waits in IDLE for a new trigger.
REQ-025 After reset with AUTO_RESTART=1, a non-zero value SHALL trigger a conversion on the first clock edge after release.

Verification
REQ-026 Release reset, pulse start with value=1234 -> busy for 15 cycles, done pulse 15 edges later, digits 4,3,2,1 (digit0..3), overflow=0, lead_mask=1111.
REQ-027 value=0, then value=9999 -> 0,0,0,0 with lead_mask=0001; 9,9,9,9 with lead_mask=1111; overflow=0 in both cases.
REQ-028 value=16383, and separately value=10000 -> 9,9,9,9 and overflow=1 in both cases; a following conversion of 70 gives 0,7,0,0 (digit0..3), lead_mask=0011 and overflow=0.
REQ-029 Start at edge N with value=5; re-pulse start at N+5 with value changed to 42 -> single done at N+15 with result 5, no second conversion; outputs unchanged between N+1 and N+14.
REQ-030 Assert reset at N+7 during a conversion of 8888 -> outputs return to the reset values, no done pulse; a new start of 321 completes normally.
REQ-031 AUTO_RESTART=1, value stepped 0 -> 1 -> 2, with each step held at least 16 cycles -> exactly one done per change, results 1 then 2, start held low throughout.
